rpi_interrupt_clkgen: RTL and testbench
=======================================

Name: rpi_interrupt_clkgen

Overview:
Parametrised, programmable successor to the fixed divide-by-64 interrupt clock. Divides clk_in by a runtime half-period to give a 50% duty clk_out. Offers continuous or N-pulse burst mode, glitch-free stop on enable drop, and single-cycle edge ticks. Sits between the 50 MHz codec clock domain and the RPi interrupt line; edge ticks feed local I2S sequencing logic.

Parameters:
CNT_W, 6, width of half_period and internal divide counter
BURST_W, 8, width of burst_len and remaining-pulse counter
DEFAULT_HALF, 32, half-period loaded at reset (32 -> 50 MHz/64, matching legacy rate)

Ports:
clk_in  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-high reset
interrupt_enable  input  1  level; high requests clock generation
half_period  input  CNT_W  clk_in cycles per clk_out half; 0 treated as 1
burst_len  input  BURST_W  pulses per run; 0 = continuous
clk_out  output  1  divided clock, registered
rise_tick  output  1  1-cycle pulse, same cycle clk_out goes 1
fall_tick  output  1  1-cycle pulse, same cycle clk_out goes 0
burst_done  output  1  1-cycle pulse when final burst pulse completes
busy  output  1  high when state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, clk_out=0, ticks=0, burst_done=0, hp_q=DEFAULT_HALF, rem=0.
- All outputs registered. Frequency = clk_in/(2*hp_q); hp_q = max(half_period,1).
- IDLE: clk_out=0. At edge k with interrupt_enable=1 -> latch hp_q and rem=burst_len, cnt=0, state RUN.
- RUN: each edge, if cnt==hp_q-1, toggle clk_out and cnt=0; else cnt+1. First rise at edge k+hp_q; every half lasts exactly hp_q cycles.
- Rising toggle: rise_tick=1 that cycle. Falling toggle: fall_tick=1. If rem!=0, rem decrements; on 1->0: burst_done=1, state IDLE.
- Enable drops in RUN with clk_out=0: state IDLE next edge, cnt=0. No extra edge, no runt.
- Enable drops in RUN with clk_out=1: state STOP. High half completes in full, then falls with fall_tick; state IDLE. No burst_done, even if rem would hit 0 on that fall.
- STOP ignores interrupt_enable. If still high in IDLE, restarts on the next edge, so minimum low time is 1 + hp_q cycles.
- Burst with enable held: after burst_done, IDLE restarts next edge. Repeated bursts are separated by 1 cycle plus the low half.
- half_period and burst_len changes during RUN/STOP are ignored until the next IDLE->RUN (unless the feature below is enabled).
- hp_q=1: clk_out toggles every edge, period 2, rise_tick/fall_tick alternate each cycle.
- cnt width CNT_W; hp_q max 2^CNT_W-1. No wrap possible since cnt resets at hp_q-1.
- Reset mid-run: clk_out forced 0 immediately (async), all state cleared.

Optional Feature:
RPI_CLK_LIVE_DIV_EN
- Defined: hp_q is also re-sampled from half_period at every falling toggle in RUN, so the new rate applies from the next low half; period boundaries stay whole.
- Undefined: hp_q is latched only on IDLE->RUN.

Decomposition:
- Package rpi_clk_pkg: state encoding IDLE/RUN/STOP (2-bit typedef) and constant MIN_HALF=1.
- Sub-module rpi_clk_half_counter (cnt, hp_q compare, toggle strobe) is natural; the FSM, burst counter and ticks stay in the top module.

Test Plan:
- Reset, half_period=32, burst_len=0, enable high at edge 10 -> first rise at edge 42, period 64, duty 32/32, rise_tick once per period.
- half_period=3, burst_len=4, enable held -> 4 rises, burst_done on 4th fall (edge k+24), busy low 1 cycle, then restart.
- half_period=5, enable dropped 2 cycles into high half -> high lasts 5 cycles total, fall_tick once, busy low after, no burst_done.
- half_period=0 -> behaves as 1: clk_out toggles each edge, period 2.
- reset asserted mid-high-half -> clk_out 0 asynchronously, busy 0; after release, restart with latency hp_q.
- RPI_CLK_LIVE_DIV_EN: half_period 4->2 during RUN -> next low half is 2 cycles. Without the macro, period stays 8.

Source files
------------

// File: rtl/rpi_clk_pkg.sv
// Shared state encoding and constants for the programmable interrupt clock generator.
package rpi_clk_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } clk_state_e;

  localparam int MIN_HALF = 1;
endpackage

// File: rtl/rpi_clk_half_counter.sv
// Half-period divide counter: strobes toggle_o on the last cycle of each clk_out half.
module rpi_clk_half_counter
  import rpi_clk_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] hp_i,
  output logic             toggle_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // hp_i is never below MIN_HALF, so the subtraction cannot wrap.
  assign toggle_o = en_i && (cnt_q == hp_i - CNT_W'(MIN_HALF));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = toggle_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rpi_interrupt_clkgen.sv
// Programmable 50% duty interrupt clock with burst mode and glitch-free stop.
// Define RPI_CLK_LIVE_DIV_EN to re-sample half_period at every falling toggle.
module rpi_interrupt_clkgen
  import rpi_clk_pkg::*;
#(
  parameter int CNT_W        = 6,
  parameter int BURST_W      = 8,
  parameter int DEFAULT_HALF = 32
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               interrupt_enable,
  input  logic [CNT_W-1:0]   half_period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               clk_out,
  output logic               rise_tick,
  output logic               fall_tick,
  output logic               burst_done,
  output logic               busy
);
  clk_state_e         state_q, state_d;
  logic               clk_q, clk_d;
  logic               rise_q, rise_d, fall_q, fall_d, done_q, done_d, busy_q, busy_d;
  logic [CNT_W-1:0]   hp_q, hp_d, hp_sel;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               cnt_clr, cnt_en, toggle;

  assign hp_sel = (half_period == '0) ? CNT_W'(MIN_HALF) : half_period;

  rpi_clk_half_counter #(.CNT_W(CNT_W)) u_half_cnt (
    .clk_in   (clk_in),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .hp_i     (hp_q),
    .toggle_o (toggle)
  );

  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    done_d  = 1'b0;
    hp_d    = hp_q;
    rem_d   = rem_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        clk_d   = 1'b0;
        if (interrupt_enable) begin
          hp_d    = hp_sel;
          rem_d   = burst_len;
          state_d = RUN;
        end
      end
      RUN: begin
        // Enable lost while low: stop before any further rising edge.
        if (!interrupt_enable && !clk_q) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (toggle) begin
            clk_d = ~clk_q;
            if (!clk_q) rise_d = 1'b1;
            else begin
              fall_d = 1'b1;
              if (!interrupt_enable) state_d = IDLE;
              else begin
`ifdef RPI_CLK_LIVE_DIV_EN
                hp_d = hp_sel;
`endif
                if (rem_q != '0) begin
                  rem_d = rem_q - BURST_W'(1);
                  if (rem_q == BURST_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                  end
                end
              end
            end
          end else if (!interrupt_enable) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Finish the high half in full, then park low without burst_done.
        cnt_en = 1'b1;
        if (toggle) begin
          clk_d   = 1'b0;
          fall_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      hp_q    <= CNT_W'(DEFAULT_HALF);
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      hp_q    <= hp_d;
      rem_q   <= rem_d;
    end
  end

  assign clk_out    = clk_q;
  assign rise_tick  = rise_q;
  assign fall_tick  = fall_q;
  assign burst_done = done_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_rpi_interrupt_clkgen.sv
// Scoreboard bench: stimulus queues hand-computed events, a negedge monitor pops and compares.
module tb_rpi_interrupt_clkgen;
  localparam int CNT_W   = 6;
  localparam int BURST_W = 8;

  logic               clk_in = 1'b0;
  logic               reset = 1'b1;
  logic               interrupt_enable = 1'b0;
  logic [CNT_W-1:0]   half_period = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic               clk_out, rise_tick, fall_tick, burst_done, busy;

  rpi_interrupt_clkgen #(.CNT_W(CNT_W), .BURST_W(BURST_W), .DEFAULT_HALF(32)) dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .interrupt_enable (interrupt_enable),
    .half_period      (half_period),
    .burst_len        (burst_len),
    .clk_out          (clk_out),
    .rise_tick        (rise_tick),
    .fall_tick        (fall_tick),
    .burst_done       (burst_done),
    .busy             (busy)
  );

  always #10 clk_in = ~clk_in;

  // cyc == n at the negedge following posedge number n
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef enum int {K_RISE, K_FALL, K_DONE, K_BUP, K_BDN} kind_e;
  typedef struct {kind_e kind; int cyc;} evt_t;

  evt_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic busy_prev = 1'b0;

  task automatic push(kind_e k, int c);
    evt_t e;
    e.kind = k;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // return at the negedge just before posedge n, so inputs driven now are sampled at edge n
  task automatic at(int n);
    do @(negedge clk_in); while (cyc < n - 1);
  endtask

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic got(kind_e k);
    evt_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got %s at cyc %0d, none expected", k.name(), cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        failures++;
        $display("FAIL event: got %s at cyc %0d expected %s at cyc %0d",
                 k.name(), cyc, e.kind.name(), e.cyc);
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (rise_tick) begin
      got(K_RISE);
      chk("level_on_rise", clk_out, 1'b1);
    end
    if (fall_tick) begin
      got(K_FALL);
      chk("level_on_fall", clk_out, 1'b0);
    end
    if (burst_done) got(K_DONE);
    if (busy && !busy_prev) got(K_BUP);
    if (!busy && busy_prev) got(K_BDN);
    busy_prev = busy;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #5;
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rise", rise_tick, 1'b0);
    chk("rst_fall", fall_tick, 1'b0);
    chk("rst_done", burst_done, 1'b0);
    at(4);
    reset = 1'b0;

    // continuous, default-rate divide by 64
    push(K_BUP, 10); push(K_RISE, 42); push(K_FALL, 74);
    push(K_RISE, 106); push(K_FALL, 138); push(K_BDN, 140);
    at(10);
    half_period = 6'd32; burst_len = 8'd0; interrupt_enable = 1'b1;
    at(140);
    interrupt_enable = 1'b0;

    // burst of 4 with enable held, then automatic restart
    push(K_BUP, 150);
    push(K_RISE, 153); push(K_FALL, 156); push(K_RISE, 159); push(K_FALL, 162);
    push(K_RISE, 165); push(K_FALL, 168); push(K_RISE, 171); push(K_FALL, 174);
    push(K_DONE, 174); push(K_BDN, 174); push(K_BUP, 175);
    push(K_RISE, 178); push(K_FALL, 181); push(K_BDN, 182);
    at(150);
    half_period = 6'd3; burst_len = 8'd4; interrupt_enable = 1'b1;
    at(182);
    interrupt_enable = 1'b0;

    // enable dropped mid-high: full high half, no burst_done even with rem=1
    push(K_BUP, 200); push(K_RISE, 205); push(K_FALL, 210); push(K_BDN, 210);
    at(200);
    half_period = 6'd5; burst_len = 8'd1; interrupt_enable = 1'b1;
    at(207);
    interrupt_enable = 1'b0;

    // half_period 0 behaves as 1
    push(K_BUP, 220);
    push(K_RISE, 221); push(K_FALL, 222); push(K_RISE, 223); push(K_FALL, 224);
    push(K_RISE, 225); push(K_FALL, 226); push(K_BDN, 226);
    at(220);
    half_period = 6'd0; burst_len = 8'd0; interrupt_enable = 1'b1;
    at(226);
    interrupt_enable = 1'b0;

    // async reset mid-high, then restart
    push(K_BUP, 240); push(K_RISE, 244); push(K_BDN, 246);
    push(K_BUP, 248); push(K_RISE, 252); push(K_FALL, 256); push(K_BDN, 256);
    at(240);
    half_period = 6'd4; interrupt_enable = 1'b1;
    at(246);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_clk_out", clk_out, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    at(248);
    reset = 1'b0;
    at(253);
    interrupt_enable = 1'b0;

    // half_period change during RUN
    push(K_BUP, 270); push(K_RISE, 274); push(K_FALL, 278);
`ifdef RPI_CLK_LIVE_DIV_EN
    push(K_RISE, 280); push(K_FALL, 282); push(K_RISE, 284); push(K_FALL, 286);
`else
    push(K_RISE, 282); push(K_FALL, 286);
`endif
    push(K_BDN, 287);
    at(270);
    half_period = 6'd4; interrupt_enable = 1'b1;
    at(276);
    half_period = 6'd2;
    at(287);
    interrupt_enable = 1'b0;

    at(300);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_events: got %0d left, expected 0 (next %s at cyc %0d)",
               q.size(), q[0].kind.name(), q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
